// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit stability counter for slide switches.
// Emits a clean switch word, rise/fall strobes and a sticky change event held until acked.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             sw_event,
  output logic [WIDTH-1:0] event_mask,
  input  logic             event_ack
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;

  // A bit is accepted on the edge that would complete its run of differing samples.
  always_comb begin
    differ = sync2 ^ switches;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = differ[i] && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      switches   <= '0;
      rise       <= '0;
      fall       <= '0;
      sw_event   <= 1'b0;
      event_mask <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= sw_raw;
      sync2    <= sync1;
      switches <= switches ^ accept;
      rise     <= accept & sync2;
      fall     <= accept & ~sync2;
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      // An ack that coincides with a new change keeps that change pending.
      if (event_ack) begin
        event_mask <= accept;
        sw_event   <= |accept;
      end else begin
        event_mask <= event_mask | accept;
        sw_event   <= sw_event | (|accept);
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with a short debounce window: directed table, corner sequences
// and randomized traffic against a sliding-window reference model.
module tb_switch_debouncer;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] switches, rise, fall, event_mask;
  logic         sw_event;
  logic         event_ack;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .switches   (switches),
    .rise       (rise),
    .fall       (fall),
    .sw_event   (sw_event),
    .event_mask (event_mask),
    .event_ack  (event_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] raw;
    logic         ack;
    logic [W-1:0] sw;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
    logic         ev;
    logic [W-1:0] mask;
  } vec_t;
  vec_t tbl[$];

  // Reference model: a level is taken once the last DC synchronized samples all
  // disagree with the current debounced value; samples lag the pads by two edges.
  logic [W-1:0] dly[$];
  logic [W-1:0] smp_q[$];
  logic [W-1:0] m_sw, m_rs, m_fl, m_mask;
  logic         m_ev;

  function automatic void model_reset();
    dly = '{8'h00, 8'h00};
    smp_q = {};
    m_sw = '0; m_rs = '0; m_fl = '0; m_mask = '0; m_ev = 1'b0;
  endfunction

  function automatic void model_edge(input logic [W-1:0] raw, input logic ack);
    logic [W-1:0] smp, acc;
    smp = dly.pop_front();
    dly.push_back(raw);
    smp_q.push_back(smp);
    if (smp_q.size() > DC) void'(smp_q.pop_front());
    acc = '0;
    if (smp_q.size() == DC) begin
      acc = '1;
      foreach (smp_q[j]) acc &= (smp_q[j] ^ m_sw);
    end
    m_rs = acc & smp;
    m_fl = acc & ~smp;
    m_sw = m_sw ^ acc;
    if (ack) begin
      m_mask = acc; m_ev = |acc;
    end else begin
      m_mask = m_mask | acc; m_ev = m_ev | (|acc);
    end
  endfunction

  function automatic void add(input logic [W-1:0] raw, input logic ack, input logic [W-1:0] sw,
                              input logic [W-1:0] rs, input logic [W-1:0] fl, input logic ev,
                              input logic [W-1:0] mask);
    vec_t v;
    v.raw = raw; v.ack = ack; v.sw = sw; v.rs = rs; v.fl = fl; v.ev = ev; v.mask = mask;
    tbl.push_back(v);
  endfunction

  function automatic logic [4*W:0] dut_out();
    return {switches, rise, fall, sw_event, event_mask};
  endfunction

  task automatic chk(input string name, input logic [4*W:0] act, input logic [4*W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got sw=%h rise=%h fall=%h ev=%b mask=%h, expected sw=%h rise=%h fall=%h ev=%b mask=%h",
               name, act[32:25], act[24:17], act[16:9], act[8], act[7:0],
               exp[32:25], exp[24:17], exp[16:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply inputs before the edge, advance the model on the edge, sample 1 time unit later.
  task automatic step(input logic [W-1:0] raw, input logic ack);
    sw_raw = raw; event_ack = ack;
    @(posedge clk);
    model_edge(raw, ack);
    #1;
    chk("model", dut_out(), {m_sw, m_rs, m_fl, m_ev, m_mask});
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset", dut_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] raw;

  initial begin
    rst_n = 1'b0; sw_raw = '0; event_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", dut_out(), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) add(8'h05, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    add(8'h05, 0, 8'h05, 8'h05, 8'h00, 1, 8'h05);
    add(8'h05, 0, 8'h05, 8'h00, 8'h00, 1, 8'h05);
    for (int i = 0; i < 5; i++) add(8'h00, 0, 8'h05, 8'h00, 8'h00, 1, 8'h05);
    add(8'h00, 0, 8'h00, 8'h00, 8'h05, 1, 8'h05);
    add(8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 8'h05);
    for (int i = 0; i < 5; i++) add(8'h80, 0, 8'h00, 8'h00, 8'h00, 1, 8'h05);
    add(8'h80, 1, 8'h80, 8'h80, 8'h00, 1, 8'h80);
    add(8'h80, 1, 8'h80, 8'h00, 8'h00, 0, 8'h00);
    add(8'h80, 0, 8'h80, 8'h00, 8'h00, 0, 8'h00);

    foreach (tbl[i]) begin
      sw_raw = tbl[i].raw; event_ack = tbl[i].ack;
      @(posedge clk);
      model_edge(tbl[i].raw, tbl[i].ack);
      #1;
      chk($sformatf("table[%0d]", i), dut_out(),
          {tbl[i].sw, tbl[i].rs, tbl[i].fl, tbl[i].ev, tbl[i].mask});
    end

    // Bounce on bit 3: 1,0,1 at 2-cycle spacing, then held high.
    step(8'h88, 0); step(8'h88, 0); step(8'h80, 0); step(8'h80, 0);
    for (int i = 0; i < 5; i++) step(8'h88, 0);
    chk8("bounce_hold", switches, 8'h80);
    step(8'h88, 0);
    chk8("bounce_accept_sw", switches, 8'h88);
    chk8("bounce_accept_rise", rise, 8'h08);
    step(8'h88, 0);
    chk8("bounce_rise_single", rise, 8'h00);
    step(8'h88, 1);
    step(8'h88, 0);

    // Reset while bit 1 has counted two of four samples.
    for (int i = 0; i < 4; i++) step(8'h8A, 0);
    async_reset();
    for (int i = 0; i < 5; i++) step(8'h8A, 0);
    chk8("post_reset_wait", switches, 8'h00);
    step(8'h8A, 0);
    chk8("post_reset_sw", switches, 8'h8A);
    chk8("post_reset_rise", rise, 8'h8A);

    raw = 8'h8A;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) raw ^= 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) async_reset();
      step(raw, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
